// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle between a same-clock producer/consumer pair and sync_fifo_flags.
// master = the producer/consumer side, slave = the FIFO.
interface sync_fifo_flags_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 5
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             walmost_full;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output wdata, winc, rinc, clr_err,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, clr_err,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 5,
  parameter int AFULL_THR  = 24,
  parameter int AEMPTY_THR = 4,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_THR = (ASIZE+1)'(AFULL_THR);
  localparam logic [ASIZE:0] AE_THR = (ASIZE+1)'(AEMPTY_THR);

  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_THR out of range 1..2**ASIZE");
  end
  if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_THR out of range 0..2**ASIZE-1");
  end

  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             wfull_q, wfull_d, rempty_q, rempty_d;
  logic             walmost_full_q, walmost_full_d, ralmost_empty_q, ralmost_empty_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic [DSIZE-1:0] fwft_word;
  logic             wr_acc, rd_acc;

  // Next-state: accept decisions use pre-edge flags, flags are recomputed from post-edge pointers
  always_comb begin
    wr_acc          = bus.winc & ~wfull_q;
    rd_acc          = bus.rinc & ~rempty_q;
    wptr_d          = wptr_q + {{ASIZE{1'b0}}, wr_acc};
    rptr_d          = rptr_q + {{ASIZE{1'b0}}, rd_acc};
    count_d         = wptr_d - rptr_d;
    rempty_d        = (wptr_d == rptr_d);
    wfull_d         = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                      (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    walmost_full_d  = (count_d >= AF_THR);
    ralmost_empty_d = (count_d <= AE_THR);
    // a fresh error outranks clr_err in the same cycle
    overflow_d      = (bus.winc & wfull_q)  | (overflow_q  & ~bus.clr_err);
    underflow_d     = (bus.rinc & rempty_q) | (underflow_q & ~bus.clr_err);
    rdata_d         = rdata_q;
    if (FWFT == 0 && rd_acc) rdata_d = mem_q[rptr_q[ASIZE-1:0]];
  end

  // Control state; reset discards contents by collapsing both pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
      rdata_q         <= '0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
      rdata_q         <= rdata_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ASIZE-1:0]] <= bus.wdata;
  end

  // FWFT head word; forced to zero while empty so reset shows rdata=0 in both modes
  assign fwft_word = rempty_q ? '0 : mem_q[rptr_q[ASIZE-1:0]];

  assign bus.rdata         = (FWFT != 0) ? fwft_word : rdata_q;
  assign bus.wfull         = wfull_q;
  assign bus.rempty        = rempty_q;
  assign bus.walmost_full  = walmost_full_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule
